// File: rtl/ge_channel_pkg.sv
// -----------------------------------------------------------------------------
// ge_channel_pkg
// Shared types and helpers for the Gilbert-Elliott noisy channel.
//   ge_state_t   : channel state (GOOD / BAD)
//   LFSR_MASK    : Galois feedback mask of every 32-bit LFSR in the block
//   SEED_STRIDE  : golden-ratio stride that decorrelates the per-lane seeds
//   lfsr_next()  : one right-shift Galois step
//   lane_seed()  : reset seed for lane idx (never all-zero)
//   sat_add()    : signed add clamped to a runtime width w <= SAT_MAX_W
// -----------------------------------------------------------------------------
package ge_channel_pkg;

  typedef enum logic {GE_GOOD = 1'b0, GE_BAD = 1'b1} ge_state_t;

  localparam logic [31:0] LFSR_MASK   = 32'h80200003;
  localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;
  localparam int          SAT_MAX_W   = 32;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int idx);
    logic [31:0] s;
    s = base ^ (32'(idx + 1) * SEED_STRIDE);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // Operands arrive sign-extended to SAT_MAX_W; the sum is formed one bit wider
  // so it cannot overflow, then clamped to the signed range of a w-bit value.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          w
  );
    logic signed [SAT_MAX_W:0] s, hi, lo, one;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    s   = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/ge_channel_multi_if.sv
// -----------------------------------------------------------------------------
// ge_channel_multi_if
// Streaming bus of the channel: input stream (in_valid/in_ready/in_data) and
// output stream (out_valid/out_ready/out_data/out_state).
//   master : the environment (source of in_*, sink of out_*)
//   slave  : the channel block
// -----------------------------------------------------------------------------
interface ge_channel_multi_if #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [N_LANES*DATA_W-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_LANES*DATA_W-1:0]   out_data;
  logic                        out_state;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_state
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_state
  );
endinterface

// File: rtl/ge_noise_lane.sv
// -----------------------------------------------------------------------------
// ge_noise_lane
// One lane's noise source: a 32-bit Galois LFSR whose four signed bytes are
// summed into a bell-shaped 10-bit value (-512..508), scaled by the shift for
// the supplied channel state.
//   clk, reset : clock, synchronous active-high reset (reloads SEED)
//   adv        : advance the LFSR one step at the next edge
//   state      : channel state selecting GOOD_SHIFT or BAD_SHIFT
//   noise      : scaled signed noise, DATA_W+1 bits, from the current LFSR value
// -----------------------------------------------------------------------------
module ge_noise_lane
  import ge_channel_pkg::*;
#(
  parameter logic [31:0] SEED       = 32'h1,
  parameter int          DATA_W     = 16,
  parameter int          GOOD_SHIFT = 0,
  parameter int          BAD_SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,
  input  ge_state_t                state,
  output logic signed [DATA_W:0]   noise
);

  logic [31:0]       lfsr;
  logic signed [9:0] raw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset)    lfsr <= SEED;
    else if (adv) lfsr <= lfsr_next(lfsr);
  end

  always_comb begin
    raw = 10'(signed'(lfsr[7:0]))   + 10'(signed'(lfsr[15:8])) +
          10'(signed'(lfsr[23:16])) + 10'(signed'(lfsr[31:24]));
    noise = (state == GE_BAD) ? ((DATA_W+1)'(raw) <<< BAD_SHIFT)
                              : ((DATA_W+1)'(raw) <<< GOOD_SHIFT);
  end

endmodule

// File: rtl/ge_channel_multi.sv
// -----------------------------------------------------------------------------
// ge_channel_multi
// Gilbert-Elliott noisy channel for N_LANES signed lanes. A GOOD/BAD Markov
// state, driven by a state LFSR against programmable thresholds, selects the
// noise scale; per-lane noise is added with saturation. One output register.
//   clk, reset        : clock, synchronous active-high reset
//   noise_off         : pass data through unmodified (model keeps running)
//   cfg_p_gb/cfg_p_bg : GOOD->BAD / BAD->GOOD thresholds (prob = cfg / 2^32)
//   stats_clear       : zero the statistics counters
//   bus (slave)       : valid/ready input and output streams, out_state
//   bad_samples       : samples accepted in BAD with noise on (saturating)
//   bursts            : GOOD->BAD transitions (saturating)
// -----------------------------------------------------------------------------
module ge_channel_multi
  import ge_channel_pkg::*;
#(
  parameter int          N_LANES    = 4,
  parameter int          DATA_W     = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hF0F0F0F0,
  parameter int          GOOD_SHIFT = 0,
  parameter int          BAD_SHIFT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                noise_off,
  input  logic [31:0]         cfg_p_gb,
  input  logic [31:0]         cfg_p_bg,
  input  logic                stats_clear,
  ge_channel_multi_if.slave   bus,
  output logic [31:0]         bad_samples,
  output logic [31:0]         bursts
);

  ge_state_t                  state_q, state_d;
  logic [31:0]                st_lfsr;
  logic                       accept;
  logic                       goes_bad;
  logic [N_LANES*DATA_W-1:0]  next_data;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: next-state is assigned a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == GE_GOOD) begin
      if (st_lfsr < cfg_p_gb) state_d = GE_BAD;
    end else begin
      if (st_lfsr < cfg_p_bg) state_d = GE_GOOD;
    end
  end

  assign goes_bad = (state_q == GE_GOOD) && (state_d == GE_BAD);

  // State LFSR and Markov state move only on accept so the noise sequence is
  // a function of the accepted samples alone, not of stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GE_GOOD;
      st_lfsr <= LFSR_SEED;
    end else if (accept) begin
      state_q <= state_d;
      st_lfsr <= lfsr_next(st_lfsr);
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic signed [DATA_W:0]   noise;
    logic signed [DATA_W-1:0] din;

    ge_noise_lane #(
      .SEED       (lane_seed(LFSR_SEED, i)),
      .DATA_W     (DATA_W),
      .GOOD_SHIFT (GOOD_SHIFT),
      .BAD_SHIFT  (BAD_SHIFT)
    ) u_noise (
      .clk   (clk),
      .reset (reset),
      .adv   (accept),
      .state (state_q),
      .noise (noise)
    );

    assign din = bus.in_data[i*DATA_W +: DATA_W];
    assign next_data[i*DATA_W +: DATA_W] =
      noise_off ? din
                : DATA_W'(sat_add(SAT_MAX_W'(din), SAT_MAX_W'(noise), DATA_W));
  end

  // Output register: out_state records the pre-transition state that shaped
  // this sample's noise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_state <= GE_GOOD;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= next_data;
      bus.out_state <= state_q;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      bad_samples <= '0;
      bursts      <= '0;
    end else begin
      if (accept && state_q == GE_BAD && !noise_off && bad_samples != '1)
        bad_samples <= bad_samples + 32'd1;
      if (accept && goes_bad && bursts != '1)
        bursts <= bursts + 32'd1;
    end
  end

endmodule

// File: doc/ge_channel_multi.md
Name: ge_channel_multi

Overview:
- Parametrised Gilbert-Elliott noisy channel for N_LANES signed audio lanes.
- Two-state Markov model (GOOD/BAD) with runtime-programmable transition thresholds.
- Per-lane pseudo-Gaussian noise generated on chip, with no ROM. Noise is added with saturation.
- Streaming valid/ready interface with one output register stage. Sits between the transmitter datapath and the receiver/decoder. Exports burst statistics for the host.

Parameters:
- N_LANES, 4, number of parallel data lanes.
- DATA_W, 16, signed sample width (minimum 10+BAD_SHIFT).
- LFSR_SEED, 32'hF0F0F0F0, reset seed of the state LFSR. Lane i seed = LFSR_SEED ^ ((i+1)*32'h9E3779B9); an all-zero result is replaced by 32'h1.
- GOOD_SHIFT, 0, left-shift applied to raw noise in GOOD.
- BAD_SHIFT, 4, left-shift applied to raw noise in BAD.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- noise_off  in  1  1 = pass data unmodified (model keeps running)
- cfg_p_gb  in  32  GOOD->BAD threshold (prob = cfg/2^32)
- cfg_p_bg  in  32  BAD->GOOD threshold
- stats_clear  in  1  single-cycle pulse; zeroes counters
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept
- in_data  in  N_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W], signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  N_LANES*DATA_W  noisy samples, signed
- out_state  out  1  channel state applied to the current out_data (0 GOOD, 1 BAD)
- bad_samples  out  32  count of samples emitted in BAD with noise on
- bursts  out  32  count of GOOD->BAD transitions

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_data=0, out_state=GOOD.
  - Model state=GOOD. All LFSRs reseeded. Counters=0.
  - Reset mid-stream drops the held sample; in_ready=1 the cycle after reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - accept = in_valid && in_ready.
  - On accept, the output register loads at the next edge and out_valid=1. If out_valid && out_ready && !in_valid, out_valid clears.
  - out_data and out_state stay stable while out_valid && !out_ready.
  - Latency is 1 cycle. Throughput is 1 sample per cycle under full flow.
- LFSRs:
  - 32-bit Galois, mask 32'h80200003. Shift right; if the old bit0 = 1, XOR the mask.
  - One state LFSR plus one per lane. All advance only on accept, so the output sequence is independent of stalls.
- Raw noise per lane:
  - Sum of the 4 signed bytes of the lane LFSR's current (pre-advance) value.
  - Range -512..508, 10-bit signed.
  - Scaled with an arithmetic left shift by GOOD_SHIFT or BAD_SHIFT, chosen by the current (pre-transition) state, then sign-extended to DATA_W+1.
- Add:
  - sum = in + noise in DATA_W+1 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The result never wraps.
  - noise_off=1: out = in exactly. LFSRs and the state machine still advance on accept.
- State machine (evaluated on accept, using the state LFSR pre-advance value r):
  - GOOD: r < cfg_p_gb -> BAD, else stay.
  - BAD: r < cfg_p_bg -> GOOD, else stay.
  - Comparison is strict unsigned, so cfg=0 means never transition.
  - The sample accepted in the transition cycle uses the old state. out_state reports that old state.
  - cfg values are sampled at accept and may change at any time.
- Counters (32-bit, saturating at 32'hFFFFFFFF):
  - bad_samples += 1 on accept with old state BAD and noise_off=0.
  - bursts += 1 on accept with a GOOD->BAD transition.
  - stats_clear wins over a same-cycle increment; the counter reads 0 on the next cycle.

Decomposition:
- Package ge_channel_pkg:
  - typedef enum logic {GE_GOOD=1'b0, GE_BAD=1'b1} ge_state_t.
  - LFSR_MASK=32'h80200003.
  - SEED_STRIDE=32'h9E3779B9.
  - Function lfsr_next(logic [31:0]).
  - Function sat_add(DATA_W-generic, implemented for the max width with parameterised clamp).
- Sub-module ge_noise_lane (parameters SEED, GOOD_SHIFT, BAD_SHIFT):
  - Holds the lane LFSR, advances on an adv input, outputs scaled signed noise for the supplied state.
  - Instantiated N_LANES times in a generate loop.

Test Plan:
- Passthrough: noise_off=1, in_data lane0=16'h1234, stream 100 samples, out_ready=1 -> out_data equals in_data exactly with 1-cycle latency; bursts still count if cfg_p_gb>0.
- Always GOOD: cfg_p_gb=0, 10k samples of 0 -> out_state always 0, every lane |out| <= 512, bursts=0, bad_samples=0.
- Forced BAD: cfg_p_gb=32'hFFFFFFFF, cfg_p_bg=0 -> first sample out_state=0, all later 1, bursts=1; bad_samples = N-1 after N samples; noise magnitude up to 8192.
- Saturation: BAD, in lanes=16'h7FFF and 16'h8000 -> outputs stay within [16'h8000,16'h7FFF], no wrap (checked against a reference model).
- Backpressure determinism: the same stimulus with random out_ready stalls vs always-ready -> identical out_data/out_state sequences; held data stable during stalls; in_ready=0 while stalled.
- Reset/clear: reset mid-stream -> out_valid=0 next cycle, sequence restarts identical to power-on. stats_clear coincident with a bursts increment -> bursts=0.
